control_sequencer: RTL and testbench

Command sequencer between the HPS-written 32-bit control PIO word and a processing engine. It decodes a start/opcode/argument word, issues one command to the engine over a valid/ready handshake, and tracks completion, timeout and illegal opcodes. It reports status back through a 32-bit word read by an input PIO. The HPS uses a four-phase protocol: set start, poll done/error, clear start.

---
 rtl/control_sequencer.sv | 172 +++++++++++++++++
 tb/tb_control_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Command sequencer between the HPS control PIO word and a processing engine.
// Decodes start/opcode/arg, issues one command over valid/ready, and reports status.
module control_sequencer #(
    parameter int unsigned CNT_W          = 20,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ctrl_word,
    output logic [31:0] status_word,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [2:0]  cmd_opcode,
    output logic [27:0] cmd_arg,
    input  logic        eng_done,
    output logic        cmd_abort
);

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned OP_W        = 3;
    localparam int unsigned ARG_W       = 28;
    localparam int unsigned CNT_FIELD_W = 25;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [WORD_W-1:0]  ctrl_q;
    logic               start;
    logic [OP_W-1:0]    req_opcode;
    logic [ARG_W-1:0]   req_arg;

    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_next;
    logic [CNT_W-1:0]   cnt_inc;
    logic               timeout_hit;

    logic               err_ill_q;
    logic               err_ill_next;
    logic               err_to_q;
    logic               err_to_next;
    logic [OP_W-1:0]    last_op_q;
    logic [OP_W-1:0]    last_op_next;

    logic               busy_next;
    logic               done_next;
    logic               valid_next;
    logic               abort_next;
    logic [OP_W-1:0]    opcode_next;
    logic [ARG_W-1:0]   arg_next;
    logic [WORD_W-1:0]  status_next;

    assign start      = ctrl_q[31];
    assign req_opcode = ctrl_q[30:28];
    assign req_arg    = ctrl_q[27:0];

    // Saturating busy-cycle increment; the last allowed cycle is when the
    // counter already holds TIMEOUT_CYCLES-1 before this edge.
    assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign timeout_hit = (cnt_q == CNT_LAST);

    // Next-state and next-output decode.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt_q;
        err_ill_next = err_ill_q;
        err_to_next  = err_to_q;
        last_op_next = last_op_q;
        opcode_next  = cmd_opcode;
        arg_next     = cmd_arg;
        abort_next   = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (req_opcode != '0) begin
                        opcode_next  = req_opcode;
                        arg_next     = req_arg;
                        last_op_next = req_opcode;
                        err_ill_next = 1'b0;
                        err_to_next  = 1'b0;
                        cnt_next     = '0;
                        state_next   = S_ISSUE;
                    end else begin
                        err_ill_next = 1'b1;
                        state_next   = S_ERR;
                    end
                end
            end
            S_ISSUE: begin
                cnt_next = cnt_inc;
                if (timeout_hit) begin
                    err_to_next = 1'b1;
                    abort_next  = 1'b1;
                    state_next  = S_ERR;
                end else if (cmd_ready) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                // Completion on the final allowed cycle beats the timeout.
                cnt_next = cnt_inc;
                if (eng_done) begin
                    state_next = S_DONE;
                end else if (timeout_hit) begin
                    err_to_next = 1'b1;
                    abort_next  = 1'b1;
                    state_next  = S_ERR;
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_next = S_IDLE;
                end
            end
            S_ERR: begin
                if (!start) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        busy_next   = (state_next == S_ISSUE) || (state_next == S_RUN);
        done_next   = (state_next == S_DONE);
        valid_next  = (state_next == S_ISSUE);
        status_next = {busy_next, done_next, err_ill_next, err_to_next,
                       last_op_next, CNT_FIELD_W'(cnt_next)};
    end

    // State and registered outputs; reset clears everything without an abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            ctrl_q      <= '0;
            cnt_q       <= '0;
            err_ill_q   <= 1'b0;
            err_to_q    <= 1'b0;
            last_op_q   <= '0;
            status_word <= '0;
            cmd_valid   <= 1'b0;
            cmd_opcode  <= '0;
            cmd_arg     <= '0;
            cmd_abort   <= 1'b0;
        end else begin
            state       <= state_next;
            ctrl_q      <= ctrl_word;
            cnt_q       <= cnt_next;
            err_ill_q   <= err_ill_next;
            err_to_q    <= err_to_next;
            last_op_q   <= last_op_next;
            status_word <= status_next;
            cmd_valid   <= valid_next;
            cmd_opcode  <= opcode_next;
            cmd_arg     <= arg_next;
            cmd_abort   <= abort_next;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: vector table for the command flows,
// hand-written sequences for timeout and asynchronous reset.
module tb_control_sequencer;

    localparam int unsigned CNT_W          = 8;
    localparam int unsigned TIMEOUT_CYCLES = 16;

    logic        clk;
    logic        reset;
    logic [31:0] ctrl_word;
    logic [31:0] status_word;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_opcode;
    logic [27:0] cmd_arg;
    logic        eng_done;
    logic        cmd_abort;

    int checks = 0;
    int errors = 0;

    control_sequencer #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ctrl_word   (ctrl_word),
        .status_word (status_word),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_arg     (cmd_arg),
        .eng_done    (eng_done),
        .cmd_abort   (cmd_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ctrl;
        logic        ready;
        logic        done;
        logic        valid;
        logic [2:0]  op;
        logic [27:0] arg;
        logic [31:0] status;
        logic        abort;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [31:0] ctrl, input logic ready, input logic done,
                                input logic valid, input logic [2:0] op, input logic [27:0] arg,
                                input logic [31:0] status, input logic abort);
        vec_t v;
        v.ctrl = ctrl; v.ready = ready; v.done = done; v.valid = valid;
        v.op = op; v.arg = arg; v.status = status; v.abort = abort;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Apply inputs, clock once, sample 1 time unit after the edge.
    task automatic step(input logic [31:0] ctrl, input logic ready, input logic done);
        ctrl_word = ctrl;
        cmd_ready = ready;
        eng_done  = done;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_status"}, status_word, 32'h0);
        check({tag, "_valid"}, 32'(cmd_valid), 32'h0);
        check({tag, "_op"}, 32'(cmd_opcode), 32'h0);
        check({tag, "_arg"}, 32'(cmd_arg), 32'h0);
        check({tag, "_abort"}, 32'(cmd_abort), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Normal command, opcode 2 arg 0x55
        vecs.push_back(mk(32'hA000_0055, 0, 0, 0, 3'd0, 28'h0,   32'h0000_0000, 0));
        vecs.push_back(mk(32'hA000_0055, 0, 0, 1, 3'd2, 28'h55,  32'h8400_0000, 0));
        vecs.push_back(mk(32'hA000_0055, 1, 0, 0, 3'd2, 28'h55,  32'h8400_0001, 0));
        vecs.push_back(mk(32'hA000_0055, 0, 0, 0, 3'd2, 28'h55,  32'h8400_0002, 0));
        vecs.push_back(mk(32'hA000_0055, 0, 0, 0, 3'd2, 28'h55,  32'h8400_0003, 0));
        vecs.push_back(mk(32'hA000_0055, 0, 1, 0, 3'd2, 28'h55,  32'h4400_0004, 0));
        vecs.push_back(mk(32'h0000_0000, 0, 0, 0, 3'd2, 28'h55,  32'h4400_0004, 0));
        vecs.push_back(mk(32'h0000_0000, 0, 0, 0, 3'd2, 28'h55,  32'h0400_0004, 0));
        // Backpressure: five ISSUE cycles with ready low, ctrl changes and eng_done ignored
        vecs.push_back(mk(32'h9000_0123, 0, 0, 0, 3'd2, 28'h55,  32'h0400_0004, 0));
        vecs.push_back(mk(32'h9000_0123, 0, 0, 1, 3'd1, 28'h123, 32'h8200_0000, 0));
        vecs.push_back(mk(32'h9000_0123, 0, 0, 1, 3'd1, 28'h123, 32'h8200_0001, 0));
        vecs.push_back(mk(32'hF000_0FFF, 0, 0, 1, 3'd1, 28'h123, 32'h8200_0002, 0));
        vecs.push_back(mk(32'hF000_0FFF, 0, 1, 1, 3'd1, 28'h123, 32'h8200_0003, 0));
        vecs.push_back(mk(32'h9000_0123, 0, 0, 1, 3'd1, 28'h123, 32'h8200_0004, 0));
        vecs.push_back(mk(32'h9000_0123, 0, 0, 1, 3'd1, 28'h123, 32'h8200_0005, 0));
        vecs.push_back(mk(32'h9000_0123, 1, 0, 0, 3'd1, 28'h123, 32'h8200_0006, 0));
        vecs.push_back(mk(32'h9000_0123, 0, 1, 0, 3'd1, 28'h123, 32'h4200_0007, 0));
        vecs.push_back(mk(32'h0000_0000, 0, 0, 0, 3'd1, 28'h123, 32'h4200_0007, 0));
        vecs.push_back(mk(32'h0000_0000, 0, 0, 0, 3'd1, 28'h123, 32'h0200_0007, 0));
        // Illegal opcode 0: sticky err_illegal, no cmd_valid
        vecs.push_back(mk(32'h8000_0000, 0, 0, 0, 3'd1, 28'h123, 32'h0200_0007, 0));
        vecs.push_back(mk(32'h8000_0000, 0, 0, 0, 3'd1, 28'h123, 32'h2200_0007, 0));
        vecs.push_back(mk(32'h8000_0000, 0, 0, 0, 3'd1, 28'h123, 32'h2200_0007, 0));
        vecs.push_back(mk(32'h0000_0000, 0, 0, 0, 3'd1, 28'h123, 32'h2200_0007, 0));
        vecs.push_back(mk(32'h0000_0000, 0, 0, 0, 3'd1, 28'h123, 32'h2200_0007, 0));
        vecs.push_back(mk(32'h0000_0000, 0, 0, 0, 3'd1, 28'h123, 32'h2200_0007, 0));
        // Next accepted command clears the error and the count
        vecs.push_back(mk(32'hB000_0001, 0, 0, 0, 3'd1, 28'h123, 32'h2200_0007, 0));
        vecs.push_back(mk(32'hB000_0001, 0, 0, 1, 3'd3, 28'h1,   32'h8600_0000, 0));
        vecs.push_back(mk(32'hB000_0001, 1, 0, 0, 3'd3, 28'h1,   32'h8600_0001, 0));
        vecs.push_back(mk(32'hB000_0001, 0, 1, 0, 3'd3, 28'h1,   32'h4600_0002, 0));
        vecs.push_back(mk(32'h0000_0000, 0, 0, 0, 3'd3, 28'h1,   32'h4600_0002, 0));
        vecs.push_back(mk(32'h0000_0000, 0, 0, 0, 3'd3, 28'h1,   32'h0600_0002, 0));

        // Reset state
        reset = 1'b1; ctrl_word = '0; cmd_ready = 1'b0; eng_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_held");
        reset = 1'b0;
        step(32'h0, 0, 0);
        check_all_zero("reset_released");

        foreach (vecs[i]) begin
            step(vecs[i].ctrl, vecs[i].ready, vecs[i].done);
            check($sformatf("vec%0d_status", i), status_word, vecs[i].status);
            check($sformatf("vec%0d_valid", i), 32'(cmd_valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d_op", i), 32'(cmd_opcode), 32'(vecs[i].op));
            check($sformatf("vec%0d_arg", i), 32'(cmd_arg), 32'(vecs[i].arg));
            check($sformatf("vec%0d_abort", i), 32'(cmd_abort), 32'(vecs[i].abort));
        end

        // Timeout with no completion; start dropped mid-RUN is ignored
        step(32'h9000_0007, 0, 0);
        check("to1_load", status_word, 32'h0600_0002);
        step(32'h9000_0007, 0, 0);
        check("to1_issue_status", status_word, 32'h8200_0000);
        check("to1_issue_arg", 32'(cmd_arg), 32'h7);
        for (int i = 1; i <= 16; i++) begin
            step((i <= 4) ? 32'h9000_0007 : 32'h0, (i == 1), 1'b0);
            if (i < 16) begin
                check($sformatf("to1_c%0d_status", i), status_word, 32'h8200_0000 | 32'(i));
                check($sformatf("to1_c%0d_abort", i), 32'(cmd_abort), 32'h0);
            end else begin
                check("to1_err_status", status_word, 32'h1200_0010);
                check("to1_err_abort", 32'(cmd_abort), 32'h1);
                check("to1_err_valid", 32'(cmd_valid), 32'h0);
            end
        end
        step(32'h0, 0, 0);
        check("to1_abort_pulse_end", 32'(cmd_abort), 32'h0);
        check("to1_hold_status", status_word, 32'h1200_0010);
        step(32'h0, 0, 0);
        check("to1_idle_sticky", status_word, 32'h1200_0010);

        // Completion on the final allowed cycle wins over timeout
        step(32'h9000_0007, 0, 0);
        check("to2_load", status_word, 32'h1200_0010);
        step(32'h9000_0007, 0, 0);
        check("to2_issue_status", status_word, 32'h8200_0000);
        for (int i = 1; i <= 16; i++) begin
            step(32'h9000_0007, (i == 1), (i == 16));
            if (i < 16) begin
                check($sformatf("to2_c%0d_status", i), status_word, 32'h8200_0000 | 32'(i));
            end else begin
                check("to2_done_status", status_word, 32'h4200_0010);
            end
            check($sformatf("to2_c%0d_abort", i), 32'(cmd_abort), 32'h0);
        end
        step(32'h9000_0007, 0, 0);
        check("to2_after_abort", 32'(cmd_abort), 32'h0);
        check("to2_after_status", status_word, 32'h4200_0010);
        step(32'h0, 0, 0);
        step(32'h0, 0, 0);
        check("to2_idle_status", status_word, 32'h0200_0010);

        // Asynchronous reset in the middle of RUN
        step(32'hA000_0055, 0, 0);
        step(32'hA000_0055, 0, 0);
        check("ar_issue_status", status_word, 32'h8400_0000);
        step(32'hA000_0055, 1, 0);
        step(32'hA000_0055, 0, 0);
        check("ar_run_status", status_word, 32'h8400_0002);
        #2;
        reset = 1'b1;
        ctrl_word = '0;
        #1;
        check_all_zero("ar_immediate");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("ar_held%0d_abort", i), 32'(cmd_abort), 32'h0);
            check($sformatf("ar_held%0d_status", i), status_word, 32'h0);
        end
        #3;
        reset = 1'b0;
        step(32'h0, 0, 0);
        check_all_zero("ar_released");
        step(32'h9000_0002, 0, 0);
        check("ar_new_load", status_word, 32'h0);
        step(32'h9000_0002, 0, 0);
        check("ar_new_issue_status", status_word, 32'h8200_0000);
        check("ar_new_valid", 32'(cmd_valid), 32'h1);
        check("ar_new_op", 32'(cmd_opcode), 32'h1);
        check("ar_new_arg", 32'(cmd_arg), 32'h2);
        step(32'h9000_0002, 1, 0);
        check("ar_new_run_status", status_word, 32'h8200_0001);
        step(32'h9000_0002, 0, 1);
        check("ar_new_done_status", status_word, 32'h4200_0002);
        check("ar_new_abort", 32'(cmd_abort), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
